// File: rtl/scarv_cop_cprs_wb.sv
// Coprocessor register file for the SCARV coprocessor: 16 x 32-bit CPRs
// with three combinational read ports, a PALU byte-enabled write port, an
// arbitrated memory-unit load writeback port and outstanding-load tracking
// that drives the decode-stage hazard signal.
//
// Memory writeback handshake: a request is presented while mem_wvalid=1 and
// is accepted on a rising edge only when mem_wready=1 in that same cycle.
// mem_wready is low whenever the PALU writes (any palu_ben bit set), so the
// PALU always wins; the source must hold mem_waddr/mem_wben/mem_wdata
// stable until the accepting edge, and the request is applied whole then.
module scarv_cop_cprs_wb (
    input  logic        g_clk,
    input  logic        g_resetn,
    input  logic [3:0]  crs1_rsel,
    input  logic [3:0]  crs2_rsel,
    input  logic [3:0]  crs3_rsel,
    output logic [31:0] crs1_rdata,
    output logic [31:0] crs2_rdata,
    output logic [31:0] crs3_rdata,
    input  logic [3:0]  palu_ben,
    input  logic [3:0]  palu_waddr,
    input  logic [31:0] palu_wdata,
    input  logic        mem_wvalid,
    output logic        mem_wready,
    input  logic [3:0]  mem_waddr,
    input  logic [3:0]  mem_wben,
    input  logic [31:0] mem_wdata,
    input  logic        ld_issue,
    input  logic [3:0]  ld_rd,
    input  logic [3:0]  id_rd,
    output logic        hazard,
    output logic [15:0] pending
);

    logic [31:0] cpr_q [16];
    logic [31:0] cpr_d [16];
    logic [15:0] pending_q;
    logic [15:0] pending_d;
    logic        mem_we;

    // PALU has absolute priority over the memory writeback port.
    assign mem_wready = (palu_ben == 4'h0);
    assign mem_we     = mem_wvalid & mem_wready;

    // Reads show registered contents only; c0 is hard-wired to zero.
    assign crs1_rdata = (crs1_rsel == 4'h0) ? 32'h0 : cpr_q[crs1_rsel];
    assign crs2_rdata = (crs2_rsel == 4'h0) ? 32'h0 : cpr_q[crs2_rsel];
    assign crs3_rdata = (crs3_rsel == 4'h0) ? 32'h0 : cpr_q[crs3_rsel];

    // Hazard looks only at registered pending state, never this cycle's events.
    assign pending = pending_q;
    assign hazard  = pending_q[crs1_rsel] | pending_q[crs2_rsel] |
                     pending_q[crs3_rsel] | pending_q[id_rd];

    // Next register contents: byte-merged write from whichever port owns the cycle.
    always_comb begin
        for (int r = 0; r < 16; r++) begin
            cpr_d[r] = cpr_q[r];
        end
        if (palu_ben != 4'h0) begin
            for (int b = 0; b < 4; b++) begin
                if (palu_ben[b]) begin
                    cpr_d[palu_waddr][8*b +: 8] = palu_wdata[8*b +: 8];
                end
            end
        end else if (mem_we) begin
            for (int b = 0; b < 4; b++) begin
                if (mem_wben[b]) begin
                    cpr_d[mem_waddr][8*b +: 8] = mem_wdata[8*b +: 8];
                end
            end
        end
        cpr_d[0] = 32'h0;
    end

    // Next pending flags: accepted load data clears, a new issue sets and wins.
    always_comb begin
        pending_d = pending_q;
        if (mem_we) begin
            pending_d[mem_waddr] = 1'b0;
        end
        if (ld_issue) begin
            pending_d[ld_rd] = 1'b1;
        end
        pending_d[0] = 1'b0;
    end

    // State registers; reset drops all contents and load tracking at once.
    always_ff @(posedge g_clk or negedge g_resetn) begin
        if (!g_resetn) begin
            for (int r = 0; r < 16; r++) begin
                cpr_q[r] <= 32'h0;
            end
            pending_q <= 16'h0;
        end else begin
            for (int r = 0; r < 16; r++) begin
                cpr_q[r] <= cpr_d[r];
            end
            pending_q <= pending_d;
        end
    end

endmodule

// File: tb/tb_scarv_cop_cprs_wb.sv
// Directed testbench for scarv_cop_cprs_wb: each task drives one scenario
// and checks combinational outputs just after inputs settle and register
// state 1 ns after the rising edge.
module tb_scarv_cop_cprs_wb;

    logic        g_clk;
    logic        g_resetn;
    logic [3:0]  crs1_rsel, crs2_rsel, crs3_rsel;
    logic [31:0] crs1_rdata, crs2_rdata, crs3_rdata;
    logic [3:0]  palu_ben, palu_waddr;
    logic [31:0] palu_wdata;
    logic        mem_wvalid, mem_wready;
    logic [3:0]  mem_waddr, mem_wben;
    logic [31:0] mem_wdata;
    logic        ld_issue;
    logic [3:0]  ld_rd, id_rd;
    logic        hazard;
    logic [15:0] pending;

    int errors = 0;
    int checks = 0;

    scarv_cop_cprs_wb dut (
        .g_clk(g_clk), .g_resetn(g_resetn),
        .crs1_rsel(crs1_rsel), .crs2_rsel(crs2_rsel), .crs3_rsel(crs3_rsel),
        .crs1_rdata(crs1_rdata), .crs2_rdata(crs2_rdata), .crs3_rdata(crs3_rdata),
        .palu_ben(palu_ben), .palu_waddr(palu_waddr), .palu_wdata(palu_wdata),
        .mem_wvalid(mem_wvalid), .mem_wready(mem_wready), .mem_waddr(mem_waddr),
        .mem_wben(mem_wben), .mem_wdata(mem_wdata),
        .ld_issue(ld_issue), .ld_rd(ld_rd), .id_rd(id_rd),
        .hazard(hazard), .pending(pending)
    );

    // Clock
    initial g_clk = 1'b0;
    always #5 g_clk = ~g_clk;

    // Advance to 1 ns past the next rising edge.
    task automatic step();
        @(posedge g_clk);
        #1;
    endtask

    task automatic idle_inputs();
        palu_ben = 4'h0; palu_waddr = 4'h0; palu_wdata = 32'h0;
        mem_wvalid = 1'b0; mem_waddr = 4'h0; mem_wben = 4'h0; mem_wdata = 32'h0;
        ld_issue = 1'b0; ld_rd = 4'h0; id_rd = 4'h0;
    endtask

    task automatic palu_write(input logic [3:0] a, input logic [3:0] ben, input logic [31:0] d);
        palu_waddr = a; palu_ben = ben; palu_wdata = d;
        step();
        palu_ben = 4'h0;
    endtask

    task automatic test_reset();
        crs1_rsel = 4'd3; crs2_rsel = 4'd5; crs3_rsel = 4'd15;
        #1;
        checks++; if (crs1_rdata !== 32'h0) begin errors++; $display("FAIL reset_c3 got=%h exp=%h", crs1_rdata, 32'h0); end
        checks++; if (crs3_rdata !== 32'h0) begin errors++; $display("FAIL reset_c15 got=%h exp=%h", crs3_rdata, 32'h0); end
        checks++; if (pending !== 16'h0) begin errors++; $display("FAIL reset_pending got=%h exp=%h", pending, 16'h0); end
        checks++; if (hazard !== 1'b0) begin errors++; $display("FAIL reset_hazard got=%b exp=0", hazard); end
        checks++; if (mem_wready !== 1'b1) begin errors++; $display("FAIL reset_wready got=%b exp=1", mem_wready); end
    endtask

    task automatic test_byte_enable();
        palu_write(4'd3, 4'hF, 32'h11223344);
        crs1_rsel = 4'd3;
        #1;
        checks++; if (crs1_rdata !== 32'h11223344) begin errors++; $display("FAIL be_full got=%h exp=%h", crs1_rdata, 32'h11223344); end
        // Enables 0101 replace bytes 0 and 2 only.
        palu_waddr = 4'd3; palu_ben = 4'b0101; palu_wdata = 32'hAABBCCDD;
        #1;
        checks++; if (crs1_rdata !== 32'h11223344) begin errors++; $display("FAIL be_no_bypass got=%h exp=%h", crs1_rdata, 32'h11223344); end
        step();
        palu_ben = 4'h0;
        #1;
        checks++; if (crs1_rdata !== 32'h11BB33DD) begin errors++; $display("FAIL be_partial got=%h exp=%h", crs1_rdata, 32'h11BB33DD); end
    endtask

    task automatic test_arbitration();
        palu_waddr = 4'd4; palu_ben = 4'hF; palu_wdata = 32'h12345678;
        mem_wvalid = 1'b1; mem_waddr = 4'd6; mem_wben = 4'hF; mem_wdata = 32'hCAFEBABE;
        #1;
        checks++; if (mem_wready !== 1'b0) begin errors++; $display("FAIL arb_wready_lo got=%b exp=0", mem_wready); end
        step();
        palu_ben = 4'h0;
        crs1_rsel = 4'd4; crs2_rsel = 4'd6;
        #1;
        checks++; if (crs1_rdata !== 32'h12345678) begin errors++; $display("FAIL arb_palu_data got=%h exp=%h", crs1_rdata, 32'h12345678); end
        checks++; if (crs2_rdata !== 32'h0) begin errors++; $display("FAIL arb_mem_held got=%h exp=%h", crs2_rdata, 32'h0); end
        checks++; if (mem_wready !== 1'b1) begin errors++; $display("FAIL arb_wready_hi got=%b exp=1", mem_wready); end
        step();
        mem_wvalid = 1'b0;
        #1;
        checks++; if (crs2_rdata !== 32'hCAFEBABE) begin errors++; $display("FAIL arb_mem_data got=%h exp=%h", crs2_rdata, 32'hCAFEBABE); end
    endtask

    task automatic test_c0();
        palu_waddr = 4'd0; palu_ben = 4'hF; palu_wdata = 32'hFFFFFFFF;
        ld_issue = 1'b1; ld_rd = 4'd0;
        step();
        palu_ben = 4'h0; ld_issue = 1'b0;
        mem_wvalid = 1'b1; mem_waddr = 4'd0; mem_wben = 4'hF; mem_wdata = 32'h5A5A5A5A;
        step();
        mem_wvalid = 1'b0;
        crs3_rsel = 4'd0;
        #1;
        checks++; if (crs3_rdata !== 32'h0) begin errors++; $display("FAIL c0_zero got=%h exp=%h", crs3_rdata, 32'h0); end
        checks++; if (pending !== 16'h0) begin errors++; $display("FAIL c0_pending got=%h exp=%h", pending, 16'h0); end
    endtask

    task automatic test_hazard();
        crs1_rsel = 4'd1; crs2_rsel = 4'd1; crs3_rsel = 4'd1; id_rd = 4'd1;
        ld_issue = 1'b1; ld_rd = 4'd5; crs2_rsel = 4'd5;
        #1;
        checks++; if (hazard !== 1'b0) begin errors++; $display("FAIL hz_no_same_cycle got=%b exp=0", hazard); end
        step();
        ld_issue = 1'b0;
        #1;
        checks++; if (pending !== 16'h0020) begin errors++; $display("FAIL hz_pending_set got=%h exp=%h", pending, 16'h0020); end
        checks++; if (hazard !== 1'b1) begin errors++; $display("FAIL hz_crs2 got=%b exp=1", hazard); end
        crs2_rsel = 4'd1; id_rd = 4'd5;
        #1;
        checks++; if (hazard !== 1'b1) begin errors++; $display("FAIL hz_id_rd got=%b exp=1", hazard); end
        id_rd = 4'd2;
        #1;
        checks++; if (hazard !== 1'b0) begin errors++; $display("FAIL hz_unrelated got=%b exp=0", hazard); end
        id_rd = 4'd5;
        mem_wvalid = 1'b1; mem_waddr = 4'd5; mem_wben = 4'hF; mem_wdata = 32'h0BADF00D;
        #1;
        checks++; if (hazard !== 1'b1) begin errors++; $display("FAIL hz_clear_not_early got=%b exp=1", hazard); end
        step();
        mem_wvalid = 1'b0;
        crs1_rsel = 4'd5;
        #1;
        checks++; if (pending !== 16'h0) begin errors++; $display("FAIL hz_pending_clr got=%h exp=%h", pending, 16'h0); end
        checks++; if (hazard !== 1'b0) begin errors++; $display("FAIL hz_cleared got=%b exp=0", hazard); end
        checks++; if (crs1_rdata !== 32'h0BADF00D) begin errors++; $display("FAIL hz_load_data got=%h exp=%h", crs1_rdata, 32'h0BADF00D); end
        id_rd = 4'd0;
    endtask

    task automatic test_coincident();
        ld_issue = 1'b1; ld_rd = 4'd7;
        step();
        mem_wvalid = 1'b1; mem_waddr = 4'd7; mem_wben = 4'hF; mem_wdata = 32'h77777777;
        step();
        ld_issue = 1'b0; mem_wvalid = 1'b0;
        crs1_rsel = 4'd7;
        #1;
        checks++; if (pending !== 16'h0080) begin errors++; $display("FAIL coinc_pending got=%h exp=%h", pending, 16'h0080); end
        checks++; if (crs1_rdata !== 32'h77777777) begin errors++; $display("FAIL coinc_data got=%h exp=%h", crs1_rdata, 32'h77777777); end
        mem_wvalid = 1'b1; mem_wdata = 32'h78787878;
        step();
        mem_wvalid = 1'b0;
        #1;
        checks++; if (pending !== 16'h0) begin errors++; $display("FAIL coinc_final_clr got=%h exp=%h", pending, 16'h0); end
    endtask

    task automatic test_palu_pending_and_zero_ben();
        ld_issue = 1'b1; ld_rd = 4'd10;
        step();
        ld_issue = 1'b0;
        palu_write(4'd10, 4'hF, 32'hDEADBEEF);
        crs1_rsel = 4'd10;
        #1;
        checks++; if (crs1_rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL palu_pend_data got=%h exp=%h", crs1_rdata, 32'hDEADBEEF); end
        checks++; if (pending !== 16'h0400) begin errors++; $display("FAIL palu_pend_keep got=%h exp=%h", pending, 16'h0400); end
        mem_wvalid = 1'b1; mem_waddr = 4'd10; mem_wben = 4'h0; mem_wdata = 32'h01010101;
        step();
        mem_wvalid = 1'b0;
        #1;
        checks++; if (pending !== 16'h0) begin errors++; $display("FAIL zben_clear got=%h exp=%h", pending, 16'h0); end
        checks++; if (crs1_rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL zben_data got=%h exp=%h", crs1_rdata, 32'hDEADBEEF); end
        mem_wvalid = 1'b1; mem_waddr = 4'd10; mem_wben = 4'b1010; mem_wdata = 32'h11223344;
        step();
        mem_wvalid = 1'b0;
        #1;
        checks++; if (crs1_rdata !== 32'h11AD33EF) begin errors++; $display("FAIL mem_partial got=%h exp=%h", crs1_rdata, 32'h11AD33EF); end
    endtask

    task automatic test_async_reset();
        palu_write(4'd2, 4'hF, 32'h22222222);
        ld_issue = 1'b1; ld_rd = 4'd9;
        step();
        ld_issue = 1'b0;
        crs1_rsel = 4'd2; crs2_rsel = 4'd9;
        #1;
        checks++; if (pending !== 16'h0200) begin errors++; $display("FAIL ar_pre_pending got=%h exp=%h", pending, 16'h0200); end
        #1 g_resetn = 1'b0;
        #1;
        checks++; if (crs1_rdata !== 32'h0) begin errors++; $display("FAIL ar_c2 got=%h exp=%h", crs1_rdata, 32'h0); end
        checks++; if (pending !== 16'h0) begin errors++; $display("FAIL ar_pending got=%h exp=%h", pending, 16'h0); end
        checks++; if (hazard !== 1'b0) begin errors++; $display("FAIL ar_hazard got=%b exp=0", hazard); end
        palu_waddr = 4'd2; palu_ben = 4'hF; palu_wdata = 32'h99999999;
        #1;
        checks++; if (mem_wready !== 1'b0) begin errors++; $display("FAIL ar_wready got=%b exp=0", mem_wready); end
        step();
        checks++; if (crs1_rdata !== 32'h0) begin errors++; $display("FAIL ar_no_write got=%h exp=%h", crs1_rdata, 32'h0); end
        palu_wdata = 32'h55555555;
        #2 g_resetn = 1'b1;
        step();
        palu_ben = 4'h0;
        #1;
        checks++; if (crs1_rdata !== 32'h55555555) begin errors++; $display("FAIL ar_first_write got=%h exp=%h", crs1_rdata, 32'h55555555); end
    endtask

    initial begin
        g_resetn = 1'b0;
        idle_inputs();
        crs1_rsel = 4'h0; crs2_rsel = 4'h0; crs3_rsel = 4'h0;
        step();
        step();
        test_reset();
        g_resetn = 1'b1;
        step();
        test_byte_enable();
        test_arbitration();
        test_c0();
        test_hazard();
        test_coincident();
        test_palu_pending_and_zero_ben();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Safety net so the run always ends.
    initial begin
        #100000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1);
    end

endmodule
